// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB camera configuration sequencer.
// Table entries are {reg_addr, data}; two reserved encodings mark the end and delays.
package sccb_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } entry_t;

    localparam logic [15:0] END_MARK        = 16'hFFFF;
    localparam logic [7:0]  DELAY_REG       = 8'hF0;
    localparam logic [7:0]  DEV_ADDR_OV7670 = 8'h42;

    function automatic logic is_end(input entry_t e);
        return {e.reg_addr, e.data} == END_MARK;
    endfunction

    function automatic logic is_delay(input entry_t e);
        return (e.reg_addr == DELAY_REG) && !is_end(e);
    endfunction

endpackage

// File: rtl/sccb_config_rom.sv
// Camera register table with a registered output (one-cycle read latency).
// TABLE_ID 0 is the OV7670 bring-up table; the small alternates are compact bring-up tables.
module sccb_config_rom
    import sccb_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 80,
    parameter int TABLE_ID    = 0,
    localparam int IW         = $clog2(NUM_ENTRIES)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] idx,
    output entry_t        entry
);

    // Unlisted indices read as the end marker so a short table always terminates.
    function automatic logic [15:0] lookup(input logic [IW-1:0] i);
        logic [15:0] v;
        v = END_MARK;
        if (TABLE_ID == 1) begin
            case (int'(i))
                0:       v = 16'h1280;
                1:       v = 16'h1101;
                default: v = END_MARK;
            endcase
        end else if (TABLE_ID == 2) begin
            case (int'(i))
                0:       v = 16'hF005;
                1:       v = 16'h3A04;
                default: v = END_MARK;
            endcase
        end else begin
            case (int'(i))
                0:       v = 16'h1280;
                1:       v = 16'hF00A;
                2:       v = 16'h1101;
                3:       v = 16'h6B4A;
                4:       v = 16'h1204;
                5:       v = 16'h40D0;
                6:       v = 16'h8C00;
                7:       v = 16'h3A04;
                8:       v = 16'h0C00;
                9:       v = 16'h3E00;
                10:      v = 16'h703A;
                11:      v = 16'h7135;
                12:      v = 16'h7211;
                13:      v = 16'h73F0;
                14:      v = 16'hA202;
                default: v = END_MARK;
            endcase
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else begin
            entry <= entry_t'(lookup(idx));
        end
    end

endmodule

// File: rtl/sccb_config_seq.sv
// Walks the camera register table and issues each write to the SCCB engine,
// handling delay entries, the end marker, inter-write gaps and bounded NACK retry.
module sccb_config_seq
    import sccb_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = DEV_ADDR_OV7670,
    parameter int         NUM_ENTRIES = 80,
    parameter int         MS_CYCLES   = 50_000,
    parameter int         GAP_CYCLES  = 64,
    parameter int         MAX_RETRY   = 3,
    parameter int         TABLE_ID    = 0,
    localparam int        IW          = $clog2(NUM_ENTRIES)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_start,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_error,
    output logic [IW-1:0] cfg_idx,
    output logic          wr_start,
    output logic [7:0]    wr_dev_addr,
    output logic [7:0]    wr_reg_addr,
    output logic [7:0]    wr_data,
    input  logic          wr_done,
    input  logic          wr_nack
);

    localparam int DELAY_MAX = 255 * MS_CYCLES;
    localparam int CNT_MAX   = (DELAY_MAX > GAP_CYCLES) ? DELAY_MAX : GAP_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int RW        = $clog2(MAX_RETRY + 2);
    localparam logic [IW:0] LAST_IDX = NUM_ENTRIES[IW:0] - 1'b1;

    state_t        state, state_next;
    entry_t        rom_entry;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_cnt;
    logic          last_ack;
    logic          idx_last;
    logic          retry_ok;

    sccb_config_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .TABLE_ID    (TABLE_ID)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .idx   (idx),
        .entry (rom_entry)
    );

    assign idx_last    = ({1'b0, idx} >= LAST_IDX);
    assign retry_ok    = (retry_cnt < RW'(MAX_RETRY));
    assign cfg_idx     = idx;
    assign wr_dev_addr = DEV_ADDR;
    assign cfg_busy    = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Running past the last index without an end marker is treated as completion.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (cfg_start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (is_end(rom_entry))        state_next = S_DONE;
                else if (is_delay(rom_entry)) state_next = S_DELAY;
                else                          state_next = S_ISSUE;
            end
            S_ISSUE:  state_next = S_WAIT;
            S_WAIT: begin
                if (wr_done) state_next = (!wr_nack || retry_ok) ? S_GAP : S_ERROR;
            end
            S_GAP: begin
                if (cnt == '0) state_next = (last_ack && idx_last) ? S_DONE : S_FETCH;
            end
            S_DELAY: begin
                if (cnt == '0) state_next = idx_last ? S_DONE : S_FETCH;
            end
            S_DONE:   state_next = S_IDLE;
            S_ERROR:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: wr_start and the write fields are registered, so the pulse appears
    // the cycle after ISSUE and the fields stay put until the next issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            cnt         <= '0;
            retry_cnt   <= '0;
            last_ack    <= 1'b0;
            wr_start    <= 1'b0;
            wr_reg_addr <= '0;
            wr_data     <= '0;
            cfg_done    <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        idx       <= '0;
                        cnt       <= '0;
                        retry_cnt <= '0;
                        last_ack  <= 1'b0;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (state_next == S_DELAY) cnt <= CW'(rom_entry.data) * CW'(MS_CYCLES);
                end
                S_ISSUE: begin
                    wr_start    <= 1'b1;
                    wr_reg_addr <= rom_entry.reg_addr;
                    wr_data     <= rom_entry.data;
                end
                S_WAIT: begin
                    if (wr_done) begin
                        cnt <= CW'(GAP_CYCLES - 1);
                        if (!wr_nack) begin
                            retry_cnt <= '0;
                            last_ack  <= 1'b1;
                        end else if (retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            last_ack  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        if (last_ack && !idx_last) idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DELAY: begin
                    if (cnt == '0) begin
                        if (!idx_last) idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE:  cfg_done  <= 1'b1;
                S_ERROR: cfg_error <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sccb_config_seq.md
Name: sccb_config_seq

Overview:
Upstream sequencer for the SCCB write engine (sccb_control). Walks a table of camera register writes, {reg_addr, data} pairs, and issues each one to the engine through a start/done handshake. Supports delay entries, an end marker, and bounded retry on NACK. It runs once after power-up or on request, and reports done or error to the top-level camera bring-up logic.

Parameters:
DEV_ADDR, 8'h42, SCCB write device address forwarded with every write.
NUM_ENTRIES, 80, table depth; index width = $clog2(NUM_ENTRIES).
MS_CYCLES, 50_000, clk cycles per delay millisecond (benches override it to a small value).
GAP_CYCLES, 64, idle clk cycles enforced between consecutive writes.
MAX_RETRY, 3, extra attempts per entry after a NACK before erroring.

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-low reset (0 = in reset)
cfg_start  in  1  one-cycle request to run the table from entry 0
cfg_busy  out  1  high from accepted start until DONE or ERROR
cfg_done  out  1  sticky; set on end marker, cleared by the next accepted start
cfg_error  out  1  sticky; set when retries are exhausted, cleared by the next accepted start
cfg_idx  out  IW  current table index, for debug
wr_start  out  1  one-cycle pulse to the engine; fields below are valid in the same cycle
wr_dev_addr  out  8  = DEV_ADDR
wr_reg_addr  out  8  register address
wr_data  out  8  register data
wr_done  in  1  one-cycle pulse from the engine at the end of a transaction
wr_nack  in  1  sampled only with wr_done; 1 = any phase NACKed

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE. All outputs 0, except wr_dev_addr, which is the constant DEV_ADDR. Retry count 0, delay/gap counters 0.
- Table entry encoding, 16 bits {reg_addr, data}:
  - 16'hFFFF = end marker.
  - reg_addr 8'hF0 = delay of data ms; data 0 means no wait.
  - Any other value = write.
- The table ROM has a registered output with 1-cycle read latency.
- States:
  - IDLE: cfg_start -> FETCH; idx = 0; clear done/error and retry count; cfg_busy = 1 from the next cycle.
  - FETCH: present idx to the ROM -> DECODE next cycle.
  - DECODE: end marker -> DONE. Delay -> DELAY with the counter loaded to data*MS_CYCLES (width sized for 255*MS_CYCLES). Otherwise -> ISSUE.
  - ISSUE: drive wr_start = 1 for exactly one cycle, with reg/data latched from the entry -> WAIT.
  - WAIT: hold the latched reg/data stable.
    - On wr_done with wr_nack = 0 -> GAP, retry count cleared.
    - On wr_done with wr_nack = 1: if retry count < MAX_RETRY -> GAP with retry count +1 and the same idx (re-issue). Otherwise -> ERROR.
  - GAP: count GAP_CYCLES. Then advance idx only if the last write ACKed, and go to FETCH.
  - DELAY: count to 0, then idx+1 -> FETCH.
  - DONE: cfg_done = 1, cfg_busy = 0 -> IDLE.
  - ERROR: cfg_error = 1, cfg_busy = 0; cfg_idx freezes at the failing entry -> IDLE.
- If idx reaches NUM_ENTRIES with no end marker, treat it as an end marker (DONE).
- cfg_start while busy is ignored; no restart mid-table.
- wr_done outside WAIT is ignored.
- Only one wr_start is outstanding at any time. wr_start is never reasserted before wr_done.
- Reset mid-transaction returns to IDLE immediately; the engine is reset by the same line.
- Latency: from the cfg_start cycle to the first wr_start is 4 cycles (IDLE->FETCH->DECODE->ISSUE).

Decomposition:
- Package sccb_cfg_pkg holds:
  - state enum
  - entry struct {reg_addr, data}
  - constants END_MARK = 16'hFFFF, DELAY_REG = 8'hF0, DEV_ADDR_OV7670 = 8'h42
- One sub-module, sccb_config_rom: index in, registered 16-bit entry out. Holds the camera register table: soft reset 12=80, delay 10 ms, then the format and clock registers, ending with FFFF.

Test Plan:
- Happy path, 3-entry table {12 80, 11 01, FFFF}, MS_CYCLES = 10, GAP = 4:
  - Pulse cfg_start, with a bench engine model returning wr_done after 20 cycles and nack = 0.
  - Required: exactly two wr_start pulses, with (12,80) then (11,01), each 42-addressed.
  - Required: first wr_start 4 cycles after cfg_start; cfg_done = 1, cfg_busy = 0 at the end.
- Delay entry {F0 05, 3A 04, FFFF}, MS_CYCLES = 10: required gap of at least 50 cycles from cfg_start to the wr_start for (3A,04).
- NACK retry, MAX_RETRY = 3: NACK the first two attempts of (11,01). Required: three identical wr_start pulses, then idx advances, then cfg_done.
- Retry exhaustion: always NACK (11,01). Required: exactly 4 wr_start pulses, then cfg_error = 1, cfg_done = 0, cfg_idx = 1.
- Restart and ignore:
  - cfg_start mid-run must be ignored, with no extra wr_start.
  - A second cfg_start after done must clear cfg_done and rerun from idx 0.
- Async reset while in WAIT: all outputs 0 in the same cycle. After release, no wr_start until a new cfg_start.
